seg7_mux_decoder: RTL
=====================

SEG7_MUX_DECODER -- requirements
Module: seg7_mux_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 2: consecutive identical synchronized samples needed to accept a phase; range 1..15.
REQ-002 Parameter TIMEOUT, default 64: clk cycles without an accepted phase before the data is declared stale; range 2..65535.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 seg_bus  input  8  multiplexed display bus: bit7 = digit select (1 = tens, 0 = ones); bits 6:0 = segments gfedcba, active-high.
REQ-006 err_clr  input  1  synchronous clear of code_err.
REQ-007 tens  output  4  last committed tens digit.
REQ-008 ones  output  4  last committed ones digit.
REQ-009 frame_valid  output  1  one-cycle pulse when tens/ones update.
REQ-010 has_data  output  1  high once any frame has been committed.
REQ-011 code_err  output  1  sticky flag: an unrecognized segment pattern was accepted.
REQ-012 stale  output  1  high while no phase has been accepted for TIMEOUT cycles.

Function
REQ-013 seg_bus SHALL pass through a 2-flop synchronizer; s denotes the second flop's output.
REQ-014 Stability counter SHALL reload to 1 when s differs from its previous-cycle value, and increment otherwise, saturating at STABLE_CYCLES.
REQ-015 A phase SHALL be accepted in the cycle the counter first reaches STABLE_CYCLES; at most one acceptance per stable run.
REQ-016 Segment decode SHALL invert the table 0111111=0, 0000110=1, 1011011=2, 1001111=3, 1100110=4, 1101101=5, 1111101=6, 0000111=7, 1111111=8, 1101111=9, 0000000=4'hF (blank); any other pattern is invalid.
REQ-017 The FSM SHALL have states HUNT and HAVE_TENS.
REQ-018 HUNT: an accepted valid tens phase stores the digit in a holding register and moves to HAVE_TENS; an accepted ones phase is ignored.
REQ-019 HAVE_TENS: an accepted valid tens phase overwrites the holding register and stays in HAVE_TENS; an accepted valid ones phase commits the holding register to tens and the decoded digit to ones, pulses frame_valid, sets has_data, and returns to HUNT.
REQ-020 Commit latency: tens, ones and frame_valid SHALL update on the clock edge after the accepting cycle, all on the same edge.
REQ-021 In either state, an accepted invalid pattern SHALL set code_err, discard the holding register, and force HUNT; tens and ones are not changed.
REQ-022 If an error is detected in the same cycle err_clr is asserted, code_err SHALL remain 1.
REQ-023 The idle counter SHALL clear on every accepted phase and otherwise increment, saturating.
REQ-024 When the idle counter reaches TIMEOUT, stale SHALL be set and the FSM forced to HUNT.
REQ-025 stale SHALL clear on the next commit only, not on a bare acceptance.
REQ-026 A timeout and an acceptance in the same cycle SHALL resolve in favour of the acceptance.

Reset
REQ-027 On reset: tens=0, ones=0, frame_valid=0, has_data=0, code_err=0, stale=0, FSM=HUNT, synchronizer/holding/counters=0.
REQ-028 Reset asserted mid-frame SHALL discard any partial frame; the first commit after reset requires a fresh tens-then-ones sequence.

Verification
REQ-029 tens=2 bus (8'b1_1011011) for 4 cycles, then ones=3 (8'b0_1001111) for 4 cycles -> exactly one frame_valid pulse; tens=2, ones=3, has_data=1.
REQ-030 Stable ones=3 frame, then a 1-cycle glitch of 8'b1_1111111 -> no acceptance; outputs unchanged; no frame_valid.
REQ-031 Valid tens=5 phase, then ones pattern 7'b1010101 held 4 cycles -> code_err=1, no frame_valid, prior tens/ones kept; err_clr pulse -> code_err=0.
REQ-032 Bus frozen after a commit -> stale=1 exactly TIMEOUT cycles after the last acceptance; next valid frame (tens=9, ones=0) -> stale=0, frame_valid pulse.
REQ-033 Reset after tens=7 is accepted, then ones=1 only -> no commit; tens=0, ones=0 remain.
REQ-034 Tens 8'b1_0000000 then ones=4 -> tens=4'hF, ones=4, frame_valid pulse, code_err=0.

Source files
------------

// File: rtl/seg7_mux_decoder.sv
// Decodes a two-phase multiplexed 7-segment bus (tens/ones) into BCD digit pairs.
// Phases are debounced before decoding; framing errors and bus inactivity are flagged.
module seg7_mux_decoder #(
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_bus,
    input  logic       err_clr,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       frame_valid,
    output logic       has_data,
    output logic       code_err,
    output logic       stale
);

    localparam logic [3:0]  STABLE = 4'(STABLE_CYCLES);
    localparam logic [15:0] LIMIT  = 16'(TIMEOUT);

    typedef enum logic {HUNT, HAVE_TENS} state_t;

    logic [7:0]  sync1_reg, s_reg, prev_reg;
    logic [3:0]  cnt_reg, cnt_next;
    logic        fresh_reg, fresh_next;
    logic [15:0] idle_reg, idle_next;
    logic [3:0]  hold_reg, hold_next;
    state_t      state_reg, state_next;
    logic [3:0]  tens_next, ones_next;
    logic        fv_next, has_next, err_next, stale_next;
    logic        changed, accept, valid;
    logic [7:0]  phase;
    logic [3:0]  digit;

    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'b0111111: decode = {1'b1, 4'd0};
            7'b0000110: decode = {1'b1, 4'd1};
            7'b1011011: decode = {1'b1, 4'd2};
            7'b1001111: decode = {1'b1, 4'd3};
            7'b1100110: decode = {1'b1, 4'd4};
            7'b1101101: decode = {1'b1, 4'd5};
            7'b1111101: decode = {1'b1, 4'd6};
            7'b0000111: decode = {1'b1, 4'd7};
            7'b1111111: decode = {1'b1, 4'd8};
            7'b1101111: decode = {1'b1, 4'd9};
            7'b0000000: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'h0};
        endcase
    endfunction

    // prev_reg holds the value whose run cnt_reg describes, so it is the accepted phase.
    assign changed        = (s_reg != prev_reg);
    assign accept         = fresh_reg;
    assign phase          = prev_reg;
    assign {valid, digit} = decode(phase[6:0]);

    always_comb begin
        cnt_next = cnt_reg;
        if (changed)
            cnt_next = 4'd1;
        else if (cnt_reg < STABLE)
            cnt_next = cnt_reg + 4'd1;
        fresh_next = (cnt_next == STABLE) && (changed || (cnt_reg != STABLE));

        idle_next = idle_reg;
        if (accept)
            idle_next = '0;
        else if (idle_reg < LIMIT)
            idle_next = idle_reg + 16'd1;
    end

    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        tens_next  = tens;
        ones_next  = ones;
        fv_next    = 1'b0;
        has_next   = has_data;
        err_next   = code_err & ~err_clr;
        stale_next = stale;
        if (accept) begin
            if (!valid) begin
                err_next   = 1'b1;
                hold_next  = '0;
                state_next = HUNT;
            end else if (phase[7]) begin
                hold_next  = digit;
                state_next = HAVE_TENS;
            end else if (state_reg == HAVE_TENS) begin
                tens_next  = hold_reg;
                ones_next  = digit;
                fv_next    = 1'b1;
                has_next   = 1'b1;
                stale_next = 1'b0;
                hold_next  = '0;
                state_next = HUNT;
            end
        end else if (idle_next == LIMIT) begin
            // Acceptance takes priority, so timeout is only evaluated here.
            stale_next = 1'b1;
            hold_next  = '0;
            state_next = HUNT;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg   <= '0;
            s_reg       <= '0;
            prev_reg    <= '0;
            cnt_reg     <= '0;
            fresh_reg   <= 1'b0;
            idle_reg    <= '0;
            hold_reg    <= '0;
            state_reg   <= HUNT;
            tens        <= '0;
            ones        <= '0;
            frame_valid <= 1'b0;
            has_data    <= 1'b0;
            code_err    <= 1'b0;
            stale       <= 1'b0;
        end else begin
            sync1_reg   <= seg_bus;
            s_reg       <= sync1_reg;
            prev_reg    <= s_reg;
            cnt_reg     <= cnt_next;
            fresh_reg   <= fresh_next;
            idle_reg    <= idle_next;
            hold_reg    <= hold_next;
            state_reg   <= state_next;
            tens        <= tens_next;
            ones        <= ones_next;
            frame_valid <= fv_next;
            has_data    <= has_next;
            code_err    <= err_next;
            stale       <= stale_next;
        end
    end

endmodule
